md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Controller sequencing the multi-cycle multdiv unit for the execute stage of the pipelined processor.
- Detects mul/div (opcode 00000, ALU_op 00110/00111) in X, latches operands, pulses the unit's start, stalls the pipeline until the result is ready, then issues one writeback.
- Writeback goes to rd, or to status $r30 on exception.
- Sits between the decode/execute pipeline register and the multdiv unit; its stall feeds the F/D/X enable logic.

Parameters:
- TIMEOUT_CYCLES, 40, max BUSY cycles before a forced exception (MD_TIMEOUT_EN only)
- MUL_STATUS, 4, value written to $r30 on a mul exception
- DIV_STATUS, 5, value written to $r30 on a div exception

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- dx_valid  in  1  X stage holds a valid (non-bubble, non-flushed) instruction
- opcode  in  5  X-stage opcode
- ALU_op  in  5  X-stage ALU op field
- rd  in  5  X-stage destination register
- operandA  in  32  rs value, after bypass
- operandB  in  32  rt value, after bypass
- md_result  in  32  multdiv data_result
- md_exception  in  1  multdiv data_exception
- md_ready  in  1  multdiv data_resultRDY
- ctrl_MULT  out  1  one-cycle mul start pulse
- ctrl_DIV  out  1  one-cycle div start pulse
- md_operandA  out  32  latched operand A, stable from the start pulse through BUSY
- md_operandB  out  32  latched operand B
- stall  out  1  freeze PC, F/D and D/X; bubble into X/M
- wb_valid  out  1  writeback strobe
- wb_reg  out  5  writeback register
- wb_data  out  32  writeback data
- busy  out  1  state != IDLE

Interface rule: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (synchronous, active-high) takes the FSM to IDLE and clears all registered state. Every output reads 0 on the first cycle after reset.
- Reset has priority over all other inputs, including mid-operation: an in-flight op is abandoned with no writeback. Any md_ready arriving later is ignored while in IDLE.
- is_md = (opcode==00000) & ALU_op[4:1]==0011; is_div = ALU_op[0].
- States: IDLE, BUSY, DONE.
- IDLE:
  - start = dx_valid & is_md.
  - On start: stall=1 combinationally in the same cycle; ctrl_MULT or ctrl_DIV=1 combinationally for this cycle only.
  - At the clock edge on start, latch operandA/B, rd and is_div, clear the cycle counter, and go to BUSY.
  - md_operandA/B must equal operandA/B during the start cycle (mux: start ? live inputs : latched).
- BUSY:
  - stall=1; counter increments each cycle.
  - On md_ready: capture md_result and md_exception, then go to DONE.
  - If md_ready arrives on the first BUSY cycle, it is accepted normally (minimum latency).
- DONE, one cycle:
  - stall=0, so the mul/div leaves X at this edge; start is ignored because X still holds the same instruction.
  - wb_valid=1.
  - No exception: wb_reg=rd, wb_data=result. If rd==0, wb_valid=0.
  - Exception: wb_reg=30, wb_data = is_div ? DIV_STATUS : MUL_STATUS, zero-extended to 32 bits.
  - Next state is IDLE.
- Back-to-back mul/div: the second op is detected in the IDLE cycle that follows DONE.
- Total stall cycles = 1 (start) + BUSY cycles. Writeback occurs 1 cycle after md_ready.
- md_ready while in IDLE or DONE is ignored.
- wb_reg and wb_data are 0 whenever wb_valid=0.

Optional Feature:
- MD_TIMEOUT_EN defined: if the counter reaches TIMEOUT_CYCLES in BUSY with no md_ready, go to DONE with the exception forced. The status write is as for a real exception.
- Not defined: no counter logic; BUSY waits indefinitely for md_ready.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - opcode R_TYPE=5'b00000
  - ALU_op MUL=5'b00110, DIV=5'b00111
  - STATUS_REG=5'd30
  - MUL_STATUS/DIV_STATUS defaults
- One natural sub-module, md_operand_latch: a 32+32+5+1-bit enable register with synchronous reset, holding the operands, rd and the op type.

Test Plan:
- Reset: assert reset for 2 cycles during BUSY, with md_ready pulsed 3 cycles later -> all outputs 0, FSM stays IDLE, no wb_valid.
- mul: 7*6, rd=5, md_ready after 4 BUSY cycles -> ctrl_MULT pulses exactly once; stall high 5 cycles; next cycle wb_valid=1, wb_reg=5, wb_data=42.
- div by zero: 9/0, rd=3, md_exception=1 -> ctrl_DIV pulses once; wb_reg=30, wb_data=5. A mul overflow gives wb_data=4.
- rd=0: mul with rd=0 -> stall sequence as normal, wb_valid stays 0.
- Back-to-back: div (rd=2) then mul (rd=4), md_ready after 1 cycle each -> two writebacks; the second start occurs exactly 1 cycle after the first DONE; no duplicate start pulses.
- MD_TIMEOUT_EN with TIMEOUT_CYCLES=8 and md_ready never asserted -> DONE after 8 BUSY cycles; mul writes wb_reg=30, wb_data=4. Without the macro, stall is still high after 100 cycles.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the mul/div sequencer: state encoding, decode constants,
// status codes and the operand bundle latched at the start of an operation.
package md_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  localparam logic [4:0]  OPC_R_TYPE     = 5'b00000;
  localparam logic [4:0]  ALU_MUL        = 5'b00110;
  localparam logic [4:0]  ALU_DIV        = 5'b00111;
  localparam logic [4:0]  STATUS_REG     = 5'd30;
  localparam logic [31:0] MUL_STATUS_DEF = 32'd4;
  localparam logic [31:0] DIV_STATUS_DEF = 32'd5;

  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    logic        is_div;
  } md_op_t;

  function automatic logic is_md_op(input logic [4:0] opcode, input logic [4:0] alu_op);
    return (opcode == OPC_R_TYPE) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));
  endfunction

endpackage

// File: rtl/md_sequencer_operand_latch.sv
// Enable register holding operand A/B, destination register and op type
// for the duration of one mul/div operation; synchronous active-high reset.
module md_operand_latch
  import md_sequencer_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   en,
  input  md_op_t op_in,
  output md_op_t op_out
);

  md_op_t op_d;
  md_op_t op_q;

  always_comb begin
    op_d = op_q;
    if (en) begin
      op_d = op_in;
    end else begin
      op_d = op_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q <= '0;
    end else begin
      op_q <= op_d;
    end
  end

  assign op_out = op_q;

endmodule

// File: rtl/md_sequencer.sv
// Execute-stage sequencer for the multi-cycle multdiv unit: start pulse, stall, single writeback.
// Optional build macro MD_TIMEOUT_EN adds a BUSY watchdog that forces an exception.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter logic [31:0] MUL_STATUS = MUL_STATUS_DEF,
  parameter logic [31:0] DIV_STATUS = DIV_STATUS_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dx_valid,
  input  logic [4:0]  opcode,
  input  logic [4:0]  ALU_op,
  input  logic [4:0]  rd,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        busy
);

  md_state_e   state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        start_s;
  logic        accept_s;
  md_op_t      live_op_s;
  md_op_t      held_op_s;

  // Reset is gated into start so nothing launches during the reset cycle itself.
  assign start_s   = (state_q == ST_IDLE) && dx_valid && is_md_op(opcode, ALU_op) && !reset;
  assign accept_s  = (state_q == ST_BUSY) && md_ready;
  assign live_op_s = '{op_a: operandA, op_b: operandB, rd: rd, is_div: ALU_op[0]};

  md_operand_latch u_operand_latch (
    .clock  (clock),
    .reset  (reset),
    .en     (start_s),
    .op_in  (live_op_s),
    .op_out (held_op_s)
  );

`ifdef MD_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_s;

  assign timeout_s = (state_q == ST_BUSY) && !md_ready && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (start_s) begin
      cnt_d = 16'd0;
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (md_ready) begin
          state_d = ST_DONE;
`ifdef MD_TIMEOUT_EN
        end else if (timeout_s) begin
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result capture: a real md_ready wins over the watchdog in the same cycle.
  always_comb begin
    result_d = result_q;
    exc_d    = exc_q;
    if (accept_s) begin
      result_d = md_result;
      exc_d    = md_exception;
`ifdef MD_TIMEOUT_EN
    end else if (timeout_s) begin
      result_d = 32'd0;
      exc_d    = 1'b1;
`endif
    end else begin
      result_d = result_q;
      exc_d    = exc_q;
    end
  end

  always_comb begin
    stall       = start_s || (state_q == ST_BUSY);
    ctrl_MULT   = start_s && !ALU_op[0];
    ctrl_DIV    = start_s && ALU_op[0];
    md_operandA = start_s ? operandA : held_op_s.op_a;
    md_operandB = start_s ? operandB : held_op_s.op_b;
    busy        = (state_q != ST_IDLE);
    wb_valid    = 1'b0;
    wb_reg      = 5'd0;
    wb_data     = 32'd0;
    if (state_q == ST_DONE) begin
      if (exc_q) begin
        wb_valid = 1'b1;
        wb_reg   = STATUS_REG;
        wb_data  = held_op_s.is_div ? DIV_STATUS : MUL_STATUS;
      end else if (held_op_s.rd != 5'd0) begin
        wb_valid = 1'b1;
        wb_reg   = held_op_s.rd;
        wb_data  = result_q;
      end else begin
        wb_valid = 1'b0;
      end
    end else begin
      wb_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: the bench plays the multdiv unit and
// predicts stall/start/writeback timing from the controller's behavioural rules.
module tb_md_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        dx_valid;
  logic [4:0]  opcode, ALU_op, rd;
  logic [31:0] operandA, operandB, md_result;
  logic        md_exception, md_ready;
  logic        ctrl_MULT, ctrl_DIV, stall, wb_valid, busy;
  logic [31:0] md_operandA, md_operandB, wb_data;
  logic [4:0]  wb_reg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  md_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .dx_valid(dx_valid), .opcode(opcode), .ALU_op(ALU_op),
    .rd(rd), .operandA(operandA), .operandB(operandB), .md_result(md_result),
    .md_exception(md_exception), .md_ready(md_ready), .ctrl_MULT(ctrl_MULT),
    .ctrl_DIV(ctrl_DIV), .md_operandA(md_operandA), .md_operandB(md_operandB),
    .stall(stall), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy)
  );

  task automatic drive_idle();
    dx_valid = 1'b0; opcode = 5'd0; ALU_op = 5'd0; rd = 5'd0;
    operandA = 32'd0; operandB = 32'd0;
    md_result = 32'd0; md_exception = 1'b0; md_ready = 1'b0;
  endtask

  // Reference multdiv behaviour: signed 32-bit mul/div, exception on overflow or /0.
  function automatic void md_model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output bit exc);
    longint p;
    if (is_div) begin
      exc = (b == 32'd0);
      res = exc ? 32'hDEAD_BEEF : 32'($signed(a) / $signed(b));
    end else begin
      p   = longint'($signed(a)) * longint'($signed(b));
      exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      res = p[31:0];
    end
  endfunction

  // One mul/div in X: start cycle, lat BUSY cycles (ready on the last), then DONE.
  task automatic run_op(input string name, input bit is_div, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd_i, input int lat);
    logic [31:0] res, ed;
    logic [4:0]  er;
    bit          exc, ev;
    md_model(is_div, a, b, res, exc);
    if (exc) begin
      ev = 1'b1; er = 5'd30; ed = is_div ? 32'd5 : 32'd4;
    end else if (rd_i == 5'd0) begin
      ev = 1'b0; er = 5'd0; ed = 32'd0;
    end else begin
      ev = 1'b1; er = rd_i; ed = res;
    end
    dx_valid = 1'b1; opcode = 5'b00000; ALU_op = is_div ? 5'b00111 : 5'b00110; rd = rd_i;
    operandA = a; operandB = b;
    for (int i = 0; i <= lat + 1; i++) begin
      if (i > 0) begin
        operandA = $urandom; operandB = $urandom;
      end
      md_ready     = (i == lat) ? 1'b1 : ((i == 0 || i == lat + 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      md_result    = (i == lat) ? res : $urandom;
      md_exception = (i == lat) ? exc : 1'($urandom_range(0, 1));
      @(negedge clock);
      n_checks++;
      if (stall !== (i <= lat)) begin
        n_fail++; $display("FAIL %s stall cyc%0d: got %b want %b", name, i, stall, (i <= lat));
      end
      n_checks++;
      if (busy !== (i >= 1)) begin
        n_fail++; $display("FAIL %s busy cyc%0d: got %b want %b", name, i, busy, (i >= 1));
      end
      n_checks++;
      if ({ctrl_MULT, ctrl_DIV} !== ((i == 0) ? {!is_div, is_div} : 2'b00)) begin
        n_fail++; $display("FAIL %s start cyc%0d: got MULT=%b DIV=%b", name, i, ctrl_MULT, ctrl_DIV);
      end
      if (i <= lat) begin
        n_checks++;
        if (md_operandA !== a || md_operandB !== b) begin
          n_fail++; $display("FAIL %s operands cyc%0d: got %h/%h want %h/%h", name, i, md_operandA, md_operandB, a, b);
        end
      end
      n_checks++;
      if (i == lat + 1) begin
        if (wb_valid !== ev || wb_reg !== er || wb_data !== ed) begin
          n_fail++; $display("FAIL %s writeback: got v=%b r=%0d d=%h want v=%b r=%0d d=%h", name, wb_valid, wb_reg, wb_data, ev, er, ed);
        end
      end else if (wb_valid !== 1'b0 || wb_reg !== 5'd0 || wb_data !== 32'd0) begin
        n_fail++; $display("FAIL %s early_wb cyc%0d: got v=%b r=%0d d=%h want 0", name, i, wb_valid, wb_reg, wb_data);
      end
      @(posedge clock); #1;
    end
    md_ready = 1'b0;
  endtask

  // Idle traffic: bubbles and non-mul/div instructions must never start the unit.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      dx_valid = 1'($urandom_range(0, 1));
      opcode   = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ALU_op   = 5'($urandom_range(0, 31));
      if (dx_valid && opcode == 5'd0 && ALU_op[4:1] == 4'b0011) ALU_op = 5'd0;
      rd = 5'($urandom); operandA = $urandom; operandB = $urandom;
      md_ready = 1'($urandom_range(0, 1)); md_result = $urandom; md_exception = 1'($urandom_range(0, 1));
      @(negedge clock);
      n_checks++;
      if ({stall, ctrl_MULT, ctrl_DIV, busy, wb_valid} !== 5'b0) begin
        n_fail++; $display("FAIL idle cyc%0d: got stall=%b mult=%b div=%b busy=%b wb=%b want 0", i, stall, ctrl_MULT, ctrl_DIV, busy, wb_valid);
      end
      @(posedge clock); #1;
    end
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle(); reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({stall, ctrl_MULT, ctrl_DIV, md_operandA, md_operandB, wb_valid, wb_reg, wb_data, busy} !== '0) begin
      n_fail++; $display("FAIL reset_state: got stall=%b busy=%b wb=%b opA=%h want all 0", stall, busy, wb_valid, md_operandA);
    end
    @(posedge clock); #1;
    dx_valid = 1'b1; ALU_op = 5'b00110; rd = 5'd5; operandA = 32'd7; operandB = 32'd6;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1; dx_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      md_ready = (i == 3); md_result = 32'd42;
      @(negedge clock);
      n_checks++;
      if ({stall, ctrl_MULT, ctrl_DIV, md_operandA, md_operandB, wb_valid, wb_reg, wb_data, busy} !== '0) begin
        n_fail++; $display("FAIL reset_midop cyc%0d: got stall=%b busy=%b wb=%b r=%0d want all 0", i, stall, busy, wb_valid, wb_reg);
      end
      @(posedge clock); #1;
    end
    drive_idle();
  endtask

  task automatic test_mul();
    run_op("mul7x6", 1'b0, 32'd7, 32'd6, 5'd5, 4);
    idle_gap(3);
  endtask

  task automatic test_exception();
    run_op("div_by_zero", 1'b1, 32'd9, 32'd0, 5'd3, 3);
    idle_gap(2);
    run_op("mul_overflow", 1'b0, 32'h4000_0000, 32'd4, 5'd7, 2);
    idle_gap(2);
  endtask

  task automatic test_rd_zero();
    run_op("mul_rd0", 1'b0, 32'd11, 32'd13, 5'd0, 3);
    idle_gap(2);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_div", 1'b1, 32'd100, 32'd7, 5'd2, 1);
    run_op("b2b_mul", 1'b0, 32'd12, 32'd12, 5'd4, 1);
    idle_gap(2);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    bit          is_div;
    for (int k = 0; k < 25; k++) begin
      is_div = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 100000));
      if (is_div) b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 500));
      else        b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 5000));
      run_op("random", is_div, a, b, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             int'($urandom_range(1, 6)));
      if ($urandom_range(0, 2) != 0) idle_gap(int'($urandom_range(1, 3)));
    end
    drive_idle();
  endtask

`ifdef MD_TIMEOUT_EN
  task automatic test_timeout();
    dx_valid = 1'b1; opcode = 5'd0; ALU_op = 5'b00110; rd = 5'd9; operandA = 32'd3; operandB = 32'd5;
    md_ready = 1'b0;
    for (int i = 0; i <= 9; i++) begin
      @(negedge clock);
      n_checks++;
      if (stall !== (i <= 8)) begin
        n_fail++; $display("FAIL timeout stall cyc%0d: got %b want %b", i, stall, (i <= 8));
      end
      if (i == 9) begin
        n_checks++;
        if (wb_valid !== 1'b1 || wb_reg !== 5'd30 || wb_data !== 32'd4) begin
          n_fail++; $display("FAIL timeout writeback: got v=%b r=%0d d=%h want v=1 r=30 d=4", wb_valid, wb_reg, wb_data);
        end
      end
      @(posedge clock); #1;
    end
    idle_gap(2);
  endtask
`else
  task automatic test_timeout();
    dx_valid = 1'b1; opcode = 5'd0; ALU_op = 5'b00110; rd = 5'd9; operandA = 32'd3; operandB = 32'd5;
    md_ready = 1'b0;
    repeat (101) @(posedge clock);
    #1 dx_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (stall !== 1'b1 || busy !== 1'b1 || wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL no_timeout: got stall=%b busy=%b wb=%b want 1 1 0", stall, busy, wb_valid);
    end
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL no_timeout_recover: got stall=%b busy=%b want 0 0", stall, busy);
    end
    @(posedge clock); #1;
    idle_gap(2);
  endtask
`endif

  initial begin
    test_reset();
    test_mul();
    test_exception();
    test_rd_zero();
    test_back_to_back();
    test_random();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
